brs_adder_sched: RTL and testbench

//   Round-robin scheduler that shares one 8-bit adder datapath between NREQ requesters.

---
 rtl/brs_pkg.sv | 17 +
 rtl/brs_rr_arbiter.sv | 33 +++
 rtl/brs_adder_sched.sv | 116 +++++++++++
 tb/tb_brs_adder_sched.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brs_pkg.sv
// Shared types and constants for the brs adder scheduler.
package brs_pkg;

    localparam int unsigned DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Width of an index into n requesters, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/brs_rr_arbiter.sv
// Combinational rotate-priority arbiter: picks the first active request after ptr.
module brs_rr_arbiter
    import brs_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    logic [IDW-1:0] idx;

    // Scan indices ptr+1 .. ptr+NREQ (mod NREQ); first hit wins.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDW'((32'(ptr) + k) % NREQ);
            if (!any && req[idx]) begin
                any         = 1'b1;
                grant[idx]  = 1'b1;
                gnt_id      = idx;
            end
        end
    end

endmodule

// File: rtl/brs_adder_sched.sv
// Round-robin scheduler sharing one DW-bit adder between NREQ requesters.
// Optional feature macro: BRS_SATURATE_EN (saturate rsp_sum to all-ones on carry).
module brs_adder_sched
    import brs_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    parameter  int unsigned DW   = DW_DEF,
    localparam int unsigned IDW  = id_width(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DW-1:0]    rsp_sum,
    output logic             rsp_carry,
    output logic [IDW-1:0]   rsp_id,
    output logic             busy
);

    state_e          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  id;
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gnt_id;
    logic            any;
    logic [DW-1:0]   sel_a;
    logic [DW-1:0]   sel_b;
    logic [DW:0]     sum_full;
    logic [DW-1:0]   sum_sel;

    brs_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .grant  (grant),
        .gnt_id (gnt_id),
        .any    (any)
    );

    // Accept is only offered while idle and out of reset.
    assign req_ready = (state == IDLE && !rst) ? grant : '0;

    // Route the granted requester's operands to the capture registers.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*DW +: DW];
                sel_b = req_b[i*DW +: DW];
            end
        end
    end

    assign sum_full = {1'b0, op_a} + {1'b0, op_b};

`ifdef BRS_SATURATE_EN
    assign sum_sel = sum_full[DW] ? '1 : sum_full[DW-1:0];
`else
    assign sum_sel = sum_full[DW-1:0];
`endif

    // Control FSM with operand, result and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IDW'(NREQ - 1);
            id        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        op_a  <= sel_a;
                        op_b  <= sel_b;
                        id    <= gnt_id;
                        state <= EXEC;
                        busy  <= 1'b1;
                    end
                end
                EXEC: begin
                    rsp_sum   <= sum_sel;
                    rsp_carry <= sum_full[DW];
                    rsp_id    <= id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        ptr       <= id;
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_brs_adder_sched.sv
// Self-checking bench for brs_adder_sched (NREQ=4, DW=8); honours BRS_SATURATE_EN.
module tb_brs_adder_sched;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_sum;
    logic            rsp_carry;
    logic [1:0]      rsp_id;
    logic            busy;

    brs_adder_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected {carry, sum} from plain integer arithmetic.
    function automatic logic [8:0] ref_add(input int a, input int b);
        int s;
        logic c;
        logic [7:0] r;
        s = a + b;
        c = (s > 255);
`ifdef BRS_SATURATE_EN
        r = c ? 8'hFF : 8'(s % 256);
`else
        r = 8'(s % 256);
`endif
        return {c, r};
    endfunction

    // Transaction-level reference: round-robin pick, 2-cycle result latency, hold until accepted.
    bit   mon_en = 0;
    bit   pend = 0;
    int   ptr_m = NREQ - 1;
    int   age = 0;
    int   g;
    int   e_id;
    logic [8:0] e_res;
    int   grant_q[$];
    int   grant_cyc[$];
    int   rsp_cyc[$];

    // Per-cycle scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                check("rst_req_ready", 32'(req_ready), 32'd0);
                pend  = 0;
                ptr_m = NREQ - 1;
                age   = 0;
            end else if (!pend) begin
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
                g = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    int i;
                    i = (ptr_m + k) % NREQ;
                    if (g < 0 && req_valid[i]) g = i;
                end
                if (g < 0) begin
                    check("idle_req_ready", 32'(req_ready), 32'd0);
                end else begin
                    check("grant", 32'(req_ready), 32'(1 << g));
                    e_res = ref_add(int'(req_a[g*DW +: DW]), int'(req_b[g*DW +: DW]));
                    e_id  = g;
                    pend  = 1;
                    age   = 0;
                    grant_q.push_back(g);
                    grant_cyc.push_back(cyc);
                end
            end else begin
                age++;
                check("busy", 32'(busy), 32'd1);
                check("busy_req_ready", 32'(req_ready), 32'd0);
                if (age == 1) begin
                    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
                end else begin
                    check("rsp_valid", 32'(rsp_valid), 32'd1);
                    check("rsp_sum", 32'(rsp_sum), 32'(e_res[7:0]));
                    check("rsp_carry", 32'(rsp_carry), 32'(e_res[8]));
                    check("rsp_id", 32'(rsp_id), 32'(e_id));
                    if (rsp_ready) begin
                        ptr_m = e_id;
                        pend  = 0;
                        rsp_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    task automatic clear_logs;
        grant_q.delete();
        grant_cyc.delete();
        rsp_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs.
        rst       = 1'b1;
        req_valid = NREQ'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        rsp_ready = 1'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_sum", 32'(rsp_sum), 32'd0);
        check("reset_rsp_carry", 32'(rsp_carry), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        mon_en = 1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        step(2);

        // Single request from requester 0.
        clear_logs();
        set_op(0, 8'h12, 8'h34);
        req_valid = 4'b0001;
        step(1);
        req_valid = '0;
        step(4);
        check("t2_grants", 32'(grant_q.size()), 32'd1);
        check("t2_rsps", 32'(rsp_cyc.size()), 32'd1);
        if (grant_q.size() == 1 && rsp_cyc.size() == 1) begin
            check("t2_id", 32'(grant_q[0]), 32'd0);
            check("t2_latency", 32'(rsp_cyc[0] - grant_cyc[0]), 32'd2);
        end

        // Carry case from requester 2.
        set_op(2, 8'hF0, 8'h20);
        req_valid = 4'b0100;
        step(1);
        req_valid = '0;
        step(1);
`ifdef BRS_SATURATE_EN
        check("t3_sum", 32'(rsp_sum), 32'h0FF);
`else
        check("t3_sum", 32'(rsp_sum), 32'h010);
`endif
        check("t3_carry", 32'(rsp_carry), 32'd1);
        check("t3_id", 32'(rsp_id), 32'd2);
        step(3);

        // All requesters valid: rotation order and throughput.
        do_reset();
        clear_logs();
        for (int i = 0; i < NREQ; i++) set_op(i, 8'($urandom), 8'($urandom));
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        step(18);
        req_valid = '0;
        step(4);
        check("t4_grants", 32'(grant_q.size() >= 6), 32'd1);
        if (grant_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) check("t4_order", 32'(grant_q[i]), 32'(i % NREQ));
            for (int i = 1; i < 6; i++) check("t4_spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd3);
        end

        // Consumer stall in RESP, then release.
        do_reset();
        clear_logs();
        set_op(1, 8'h7F, 8'h01);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        step(1);
        req_valid = 4'b1111;
        step(5);
        check("t5_valid_held", 32'(rsp_valid), 32'd1);
        check("t5_sum_held", 32'(rsp_sum), 32'h80);
        check("t5_id_held", 32'(rsp_id), 32'd1);
        check("t5_ready_low", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        step(2);
        req_valid = '0;
        step(4);
        check("t5_grants", 32'(grant_q.size() >= 2 && rsp_cyc.size() >= 1), 32'd1);
        if (grant_q.size() >= 2 && rsp_cyc.size() >= 1) begin
            check("t5_next_id", 32'(grant_q[1]), 32'd2);
            check("t5_next_gap", 32'(grant_cyc[1] - rsp_cyc[0]), 32'd1);
        end

        // Reset during EXEC of a grant to requester 3.
        do_reset();
        clear_logs();
        set_op(3, 8'($urandom), 8'($urandom));
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        step(1);
        rst       = 1'b1;
        req_valid = '0;
        step(1);
        rst = 1'b0;
        step(4);
        check("t6_no_rsp", 32'(rsp_cyc.size()), 32'd0);
        check("t6_grant3", 32'(grant_q.size() == 1 && grant_q[0] == 3), 32'd1);
        clear_logs();
        req_valid = 4'b1111;
        step(1);
        req_valid = '0;
        step(4);
        check("t6_first_after_rst", 32'(grant_q.size() >= 1 && grant_q[0] == 0), 32'd1);

        // Randomized traffic with occasional resets.
        do_reset();
        clear_logs();
        for (int n = 0; n < 1500; n++) begin
            req_valid = ($urandom_range(0, 3) == 0) ? 4'b0000 : NREQ'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            step(1);
        end
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        step(5);
        check("rand_ops_seen", 32'(rsp_cyc.size() > 50), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
